// File: rtl/gb_frame_scanout.sv
// gb_frame_scanout: captures the 2-bit GB pixel stream into RAM and shades it out for VGA.
// Optional macro GB_GRID_EN darkens 3x-scale cell boundaries (LCD-grid look).
module gb_frame_scanout #(
    parameter int          GB_W       = 160,
    parameter int          GB_H       = 144,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gb_pix_valid,
    input  logic [1:0]  gb_pix,
    input  logic        gb_vs,
    input  logic [7:0]  vga_gb_x,
    input  logic [7:0]  vga_gb_y,
    input  logic        vga_gb_en,
    input  logic        vga_gb_grid,
    input  logic        vga_enable,
    output logic [23:0] rgb,
    output logic        rgb_en,
    output logic        vsi_out,
    output logic        ovf
);
    localparam int          DEPTH = GB_W * GB_H;
    localparam logic [14:0] LAST  = 15'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;
    state_t      state, state_n;
    logic [14:0] waddr, waddr_n, wa;
    logic        we, ovf_n;
    logic        vs_q, vs_rise, rise_q, armed;
    logic [1:0]  mem [DEPTH];
    logic [1:0]  rdata;
    logic [14:0] raddr, raddr_n, yw;
    logic        en1, en2, ena1, ena2;
    logic [23:0] base, pix;

    assign vs_rise = gb_vs & ~vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            rise_q  <= 1'b0;
            armed   <= 1'b1;
            vsi_out <= 1'b0;
            state   <= IDLE;
            waddr   <= '0;
            ovf     <= 1'b0;
        end else begin
            vs_q    <= gb_vs;
            rise_q  <= vs_rise;
            vsi_out <= rise_q & armed;
            armed   <= armed & ~rise_q;
            state   <= state_n;
            waddr   <= waddr_n;
            ovf     <= ovf_n;
        end
    end

    // A frame-start pixel always lands at address 0, whatever the current state.
    always_comb begin
        state_n = state;
        waddr_n = waddr;
        wa      = waddr;
        we      = 1'b0;
        ovf_n   = ovf;
        if (vs_rise) begin
            state_n = ACTIVE;
            wa      = '0;
            we      = gb_pix_valid;
            waddr_n = gb_pix_valid ? 15'd1 : 15'd0;
        end else if (state == ACTIVE && gb_pix_valid) begin
            we      = 1'b1;
            waddr_n = (waddr == LAST) ? waddr : waddr + 15'd1;
            state_n = (waddr == LAST) ? FULL : ACTIVE;
        end else if (state == FULL && gb_pix_valid) begin
            ovf_n = 1'b1;
        end
    end

    assign yw      = {7'b0, vga_gb_y};
    assign raddr_n = (vga_gb_y >= 8'(GB_H) || vga_gb_x >= 8'(GB_W)) ? LAST
                   : (yw << 7) + (yw << 5) + {7'b0, vga_gb_x};

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= gb_pix;
        rdata <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr  <= '0;
            en1    <= 1'b0;
            en2    <= 1'b0;
            ena1   <= 1'b0;
            ena2   <= 1'b0;
            rgb    <= '0;
            rgb_en <= 1'b0;
        end else begin
            raddr  <= raddr_n;
            en1    <= vga_gb_en;
            en2    <= en1;
            ena1   <= vga_enable;
            ena2   <= ena1;
            rgb    <= !ena2 ? 24'h000000 : !en2 ? BORDER_RGB : pix;
            rgb_en <= ena2;
        end
    end

    assign base = (rdata == 2'd0) ? 24'hE0F8D0
                : (rdata == 2'd1) ? 24'h88C070
                : (rdata == 2'd2) ? 24'h346856 : 24'h081820;

`ifdef GB_GRID_EN
    logic grid1, grid2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid1 <= 1'b0;
            grid2 <= 1'b0;
        end else begin
            grid1 <= vga_gb_grid;
            grid2 <= grid1;
        end
    end

    function automatic logic [7:0] dim(input logic [7:0] c);
        return c - (c >> 3);
    endfunction

    assign pix = (grid2 && en2) ? {dim(base[23:16]), dim(base[15:8]), dim(base[7:0])} : base;
`else
    logic unused_grid;
    assign unused_grid = vga_gb_grid;
    assign pix         = base;
`endif
endmodule

// File: tb/tb_gb_frame_scanout.sv
// tb_gb_frame_scanout: table-driven checks of capture, shading, overflow, resync and reset.
module tb_gb_frame_scanout;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        gb_pix_valid, gb_vs, vga_gb_en, vga_gb_grid, vga_enable;
    logic [1:0]  gb_pix;
    logic [7:0]  vga_gb_x, vga_gb_y;
    logic [23:0] rgb;
    logic        rgb_en, vsi_out, ovf;
    int          errors = 0, checks = 0;

`ifdef GB_GRID_EN
    localparam logic [23:0] G0 = 24'hC4D9B6, G3 = 24'h07151C;
`else
    localparam logic [23:0] G0 = 24'hE0F8D0, G3 = 24'h081820;
`endif

    typedef struct {
        logic [7:0]  x, y;
        logic        en, grid, ena;
        logic [23:0] rgb;
        logic        rgb_en;
    } vec_t;
    vec_t v[12];

    gb_frame_scanout dut (
        .clk(clk), .rst_n(rst_n), .gb_pix_valid(gb_pix_valid), .gb_pix(gb_pix), .gb_vs(gb_vs),
        .vga_gb_x(vga_gb_x), .vga_gb_y(vga_gb_y), .vga_gb_en(vga_gb_en),
        .vga_gb_grid(vga_gb_grid), .vga_enable(vga_enable),
        .rgb(rgb), .rgb_en(rgb_en), .vsi_out(vsi_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        vga_gb_x    = t.x;
        vga_gb_y    = t.y;
        vga_gb_en   = t.en;
        vga_gb_grid = t.grid;
        vga_enable  = t.ena;
    endtask

    task automatic read_px(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [23:0] exp);
        drive('{x, y, 1'b1, 1'b0, 1'b1, 24'h0, 1'b0});
        repeat (3) tick();
        check(name, rgb, exp);
    endtask

    initial begin
        int pulses;
        v[0]  = '{8'd5,   8'd0,   1'b1, 1'b0, 1'b1, 24'h88C070, 1'b1};
        v[1]  = '{8'd159, 8'd143, 1'b1, 1'b0, 1'b1, 24'h081820, 1'b1};
        v[2]  = '{8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 24'hE0F8D0, 1'b1};
        v[3]  = '{8'd2,   8'd1,   1'b1, 1'b0, 1'b1, 24'h346856, 1'b1};
        v[4]  = '{8'd3,   8'd0,   1'b1, 1'b1, 1'b1, G3,         1'b1};
        v[5]  = '{8'd0,   8'd1,   1'b1, 1'b1, 1'b1, G0,         1'b1};
        v[6]  = '{8'd5,   8'd0,   1'b0, 1'b0, 1'b1, 24'h000000, 1'b1};
        v[7]  = '{8'd0,   8'd0,   1'b0, 1'b1, 1'b1, 24'h000000, 1'b1};
        v[8]  = '{8'd5,   8'd0,   1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        v[9]  = '{8'd1,   8'd100, 1'b1, 1'b0, 1'b1, 24'h88C070, 1'b1};
        v[10] = '{8'd200, 8'd10,  1'b1, 1'b0, 1'b1, 24'h081820, 1'b1};
        v[11] = '{8'd10,  8'd200, 1'b1, 1'b0, 1'b1, 24'h081820, 1'b1};

        rst_n = 1'b0; gb_pix_valid = 1'b0; gb_pix = 2'd0; gb_vs = 1'b0;
        drive('{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0});
        repeat (2) tick();
        check("reset rgb", rgb, 24'h0);
        check("reset rgb_en", {23'b0, rgb_en}, 24'h0);
        check("reset vsi", {23'b0, vsi_out}, 24'h0);
        check("reset ovf", {23'b0, ovf}, 24'h0);
        rst_n = 1'b1;
        tick();

        // Full frame; the first pixel coincides with the vs rise.
        gb_vs = 1'b1;
        pulses = 0;
        for (int i = 0; i < 23040; i++) begin
            gb_pix_valid = 1'b1;
            gb_pix = 2'(i % 4);
            tick();
            if (i == 0) check("vsi before 2 cycles", {23'b0, vsi_out}, 24'h0);
            if (i == 1) check("vsi at 2 cycles", {23'b0, vsi_out}, 24'h1);
            pulses += int'(vsi_out);
        end
        gb_pix_valid = 1'b0;
        repeat (4) begin tick(); pulses += int'(vsi_out); end
        check("vsi pulse count", 24'(pulses), 24'd1);
        check("ovf after full frame", {23'b0, ovf}, 24'h0);

        // Back-to-back stream: vector i emerges after the tick of iteration i+2.
        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(v[i]);
            else drive('{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0});
            tick();
            if (i >= 2) begin
                check($sformatf("vec%0d rgb", i - 2), rgb, v[i - 2].rgb);
                check($sformatf("vec%0d rgb_en", i - 2), {23'b0, rgb_en}, {23'b0, v[i - 2].rgb_en});
            end
        end

        // 23041st pixel is dropped and flags overflow.
        gb_pix_valid = 1'b1; gb_pix = 2'd0;
        tick();
        gb_pix_valid = 1'b0;
        tick();
        check("ovf set", {23'b0, ovf}, 24'h1);
        read_px("ram unchanged", 8'd159, 8'd143, 24'h081820);

        // Second vs rise: waddr restarts, no resync pulse, ovf sticky.
        gb_vs = 1'b0; tick();
        gb_vs = 1'b1;
        pulses = 0;
        repeat (4) begin tick(); pulses += int'(vsi_out); end
        check("no second vsi", 24'(pulses), 24'd0);
        check("ovf sticky", {23'b0, ovf}, 24'h1);
        gb_pix_valid = 1'b1; gb_pix = 2'd2;
        repeat (3) tick();
        gb_pix_valid = 1'b0;
        read_px("short frame addr0", 8'd0, 8'd0, 24'h346856);
        read_px("short frame addr2", 8'd2, 8'd0, 24'h346856);
        read_px("stale addr3", 8'd3, 8'd0, 24'h081820);

        // Same-address write/read: read sees the old shade.
        drive('{8'd3, 8'd0, 1'b1, 1'b0, 1'b1, 24'h0, 1'b0});
        tick();
        gb_pix_valid = 1'b1; gb_pix = 2'd0;
        tick();
        gb_pix_valid = 1'b0;
        tick();
        check("rdw old data", rgb, 24'h081820);
        read_px("rdw new data", 8'd3, 8'd0, 24'hE0F8D0);

        // New frame, 1000 pixels of shade 1, then async reset mid-frame.
        gb_vs = 1'b0; tick();
        gb_vs = 1'b1;
        gb_pix_valid = 1'b1; gb_pix = 2'd1;
        repeat (1000) tick();
        gb_pix_valid = 1'b0;
        read_px("pre-reset", 8'd5, 8'd0, 24'h88C070);
        #3;
        rst_n = 1'b0;
        gb_vs = 1'b0;
        #1;
        check("async rgb", rgb, 24'h0);
        check("async rgb_en", {23'b0, rgb_en}, 24'h0);
        check("async ovf", {23'b0, ovf}, 24'h0);
        check("async vsi", {23'b0, vsi_out}, 24'h0);
        tick();
        rst_n = 1'b1;
        tick();
        gb_pix_valid = 1'b1; gb_pix = 2'd3;
        repeat (10) tick();
        gb_pix_valid = 1'b0;
        read_px("idle discards", 8'd0, 8'd0, 24'h88C070);
        gb_vs = 1'b1;
        pulses = 0;
        repeat (5) begin tick(); pulses += int'(vsi_out); end
        check("vsi re-armed", 24'(pulses), 24'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
